spi_txn_scheduler: RTL and testbench

SPI_TXN_SCHEDULER -- requirements
Module: spi_txn_scheduler

---
 rtl/spi_txn_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_spi_txn_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler that turns per-requester frame requests into SPI master FIFO
// writes and collects the slave's response frame from the slave FIFO.
module spi_txn_scheduler #(
  parameter int N_REQ           = 4,
  parameter int N_SLAVES        = 3,
  parameter int BYTES_PER_FRAME = 2,
  parameter int TIMEOUT         = 1023
) (
  input  logic                               sys_clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_bus,
  input  logic [4*N_REQ-1:0]                 req_slave_bus,
  input  logic [8*BYTES_PER_FRAME*N_REQ-1:0] req_data_bus,
  output logic [N_REQ-1:0]                   gnt_bus,
  output logic [N_REQ-1:0]                   done_bus,
  output logic [N_REQ-1:0]                   err_bus,
  output logic [8*BYTES_PER_FRAME-1:0]       rsp_data,
  output logic                               busy,
  output logic [7:0]                         m_din,
  output logic [N_SLAVES-1:0]                m_wrreq_bus,
  output logic [N_SLAVES-1:0]                s_rdreq_bus,
  input  logic [7:0]                         s_dout,
  input  logic [N_SLAVES-1:0]                have_msg_bus,
  input  logic [7:0]                         len,
  output logic [2:0]                         dbg_state_o
);

  localparam int FW = 8 * BYTES_PER_FRAME;
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_LOAD, S_WAIT, S_READ, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [3:0]      slave_q, slave_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [FW-1:0]   rx_q, rx_d;
  logic [FW-1:0]   rsp_q, rsp_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            bad_q, bad_d;
  logic            phase_q, phase_d;

  logic                any_req;
  logic [OW-1:0]       pick;
  logic [N_SLAVES-1:0] slave_oh;
  logic [N_SLAVES-1:0] drain_sel;
  logic [FW-1:0]       rx_shift;
  logic [N_REQ-1:0]    gnt, done, err;
  logic [N_SLAVES-1:0] wr, rd;
  logic [7:0]          din;

  // Handshake: a requester holds req_bus[i] with stable slave/frame until its one-cycle
  // gnt_bus[i]; the frame is sampled in that cycle and later req changes are ignored.
  always_comb begin
    any_req = 1'b0;
    pick    = rr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_bus[(int'(rr_q) + k) % N_REQ]) begin
        any_req = 1'b1;
        pick    = OW'((int'(rr_q) + k) % N_REQ);
      end
    end
  end

  assign slave_oh  = (int'(slave_q) < N_SLAVES) ? (N_SLAVES'(1) << slave_q) : '0;
  assign drain_sel = have_msg_bus & (~have_msg_bus + N_SLAVES'(1));
  // Bytes enter at the top so after BYTES_PER_FRAME shifts the first byte sits in the LSBs.
  assign rx_shift  = (rx_q >> 8) | (FW'(s_dout) << (FW - 8));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    slave_d = slave_q;
    frame_d = frame_q;
    rx_d    = rx_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    phase_d = phase_q;
    gnt     = '0;
    done    = '0;
    err     = '0;
    wr      = '0;
    rd      = '0;
    din     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|have_msg_bus) begin
          state_d = S_DRAIN;
          phase_d = 1'b0;
        end else if (any_req) begin
          gnt[pick] = 1'b1;
          owner_d   = pick;
          rr_d      = (int'(pick) == N_REQ - 1) ? '0 : pick + OW'(1);
          slave_d   = req_slave_bus[4*int'(pick) +: 4];
          frame_d   = req_data_bus[FW*int'(pick) +: FW];
          cnt_d     = '0;
          if (int'(slave_d) < N_SLAVES) begin
            state_d = S_LOAD;
            bad_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            bad_d   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Strobe and gap alternate so have_msg_bus reflects each pop before the next one.
        if (phase_q) begin
          phase_d = 1'b0;
        end else if (|have_msg_bus) begin
          rd      = drain_sel;
          phase_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        wr      = slave_oh;
        din     = frame_q[7:0];
        frame_d = frame_q >> 8;
        if (cnt_q == 16'(BYTES_PER_FRAME - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if ((|(have_msg_bus & slave_oh)) && (len >= 8'(BYTES_PER_FRAME))) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt_q == 16'(TIMEOUT)) begin
          state_d = S_DONE;
          bad_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_READ: begin
        if (cnt_q < 16'(BYTES_PER_FRAME)) rd = slave_oh;
        if (cnt_q != 16'd0) rx_d = rx_shift;
        if (cnt_q == 16'(BYTES_PER_FRAME)) begin
          state_d = S_DONE;
          rsp_d   = rx_shift;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        if (bad_q) err[owner_q] = 1'b1;
        else       done[owner_q] = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      slave_q <= '0;
      frame_q <= '0;
      rx_q    <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      slave_q <= slave_d;
      frame_q <= frame_d;
      rx_q    <= rx_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      phase_q <= phase_d;
    end
  end

  // Strobes are blanked while rst is high, including the first reset cycle.
  assign gnt_bus     = gnt  & {N_REQ{~rst}};
  assign done_bus    = done & {N_REQ{~rst}};
  assign err_bus     = err  & {N_REQ{~rst}};
  assign m_wrreq_bus = wr   & {N_SLAVES{~rst}};
  assign s_rdreq_bus = rd   & {N_SLAVES{~rst}};
  assign m_din       = din  & {8{~rst}};
  assign busy        = ~rst & (state_q != S_IDLE);
  assign rsp_data    = rsp_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Randomised bench for spi_txn_scheduler: behavioural slave FIFOs plus a transaction
// scoreboard that predicts grant order, written bytes, response data and timing.
module tb_spi_txn_scheduler;

  localparam int NR = 4;
  localparam int NS = 3;
  localparam int NB = 2;
  localparam int TO = 16;
  localparam int FW = 8 * NB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_bus = '0;
  logic [4*NR-1:0]   req_slave_bus = '0;
  logic [FW*NR-1:0]  req_data_bus = '0;
  logic [NR-1:0]     gnt_bus, done_bus, err_bus;
  logic [FW-1:0]     rsp_data;
  logic              busy;
  logic [7:0]        m_din;
  logic [NS-1:0]     m_wrreq_bus, s_rdreq_bus;
  logic [7:0]        s_dout = '0;
  logic [NS-1:0]     have_msg_bus = '0;
  logic [7:0]        len = '0;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  spi_txn_scheduler #(.N_REQ(NR), .N_SLAVES(NS), .BYTES_PER_FRAME(NB), .TIMEOUT(TO)) dut (
    .sys_clk(clk), .rst(rst), .req_bus(req_bus), .req_slave_bus(req_slave_bus),
    .req_data_bus(req_data_bus), .gnt_bus(gnt_bus), .done_bus(done_bus), .err_bus(err_bus),
    .rsp_data(rsp_data), .busy(busy), .m_din(m_din), .m_wrreq_bus(m_wrreq_bus),
    .s_rdreq_bus(s_rdreq_bus), .s_dout(s_dout), .have_msg_bus(have_msg_bus), .len(len),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave FIFO model ----------------
  logic [7:0]    fifo [NS][$];
  logic [7:0]    wrb  [NS][$];
  bit            pend_on [NS];
  int            pend_cnt [NS];
  logic [FW-1:0] pend_val [NS];
  int            preload_n [NS];
  logic [FW-1:0] exp_q[$];
  bit            mute = 0;
  bit            force_on = 0;
  logic [FW-1:0] force_val = '0;
  int            max_delay = 0;
  int            last_delay = 0;
  int            len_sel = 0;
  logic [NS-1:0] ms_wr, ms_rd;
  logic [7:0]    ms_din;
  bit            ms_rst;

  always @(posedge clk) begin
    ms_wr = m_wrreq_bus; ms_rd = s_rdreq_bus; ms_din = m_din; ms_rst = rst;
    #1;
    for (int s = 0; s < NS; s++) begin
      if (ms_rst) begin
        wrb[s].delete();
        pend_on[s] = 0;
      end
      if (ms_wr[s]) begin
        wrb[s].push_back(ms_din);
        len_sel = s;
        if (wrb[s].size() == NB) begin
          wrb[s].delete();
          if (!mute) begin
            pend_val[s] = force_on ? force_val : FW'($urandom);
            pend_cnt[s] = $urandom_range(0, max_delay);
            pend_on[s]  = 1;
            last_delay  = pend_cnt[s];
            exp_q.push_back(pend_val[s]);
          end
        end
      end
      if (ms_rd[s]) s_dout = (fifo[s].size() != 0) ? fifo[s].pop_front() : 8'hEE;
      if (pend_on[s]) begin
        if (pend_cnt[s] == 0) begin
          for (int k = 0; k < NB; k++) fifo[s].push_back(pend_val[s][8*k +: 8]);
          pend_on[s] = 0;
        end else begin
          pend_cnt[s]--;
        end
      end
      for (int k = 0; k < preload_n[s]; k++) fifo[s].push_back(8'($urandom));
      preload_n[s] = 0;
    end
    if (ms_rst) exp_q.delete();
    for (int s = 0; s < NS; s++) have_msg_bus[s] = (fifo[s].size() != 0);
    len = 8'(fifo[len_sel].size());
  end

  // ---------------- transaction scoreboard ----------------
  int            cyc = 0;
  bit            inflight = 0;
  bit            cur_bad = 0;
  int            cur_owner, cur_slave, gnt_cyc, wr_k, rd_k, last_wr_cyc;
  logic [FW-1:0] cur_frame;
  logic [FW-1:0] last_rsp = '0;
  int            next_rr = 0;
  int            exp_g;
  int            gnt_log[$];
  logic [NR-1:0] gnt_seen = '0;
  int            done_cnt = 0, err_cnt = 0, drain_rd = 0;
  logic [NS-1:0] low_msg;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      inflight = 0;
      next_rr  = 0;
      last_rsp = '0;
    end else begin
      check_eq("onehot", $onehot0(gnt_bus) && $onehot0(done_bus) && $onehot0(err_bus) &&
               $onehot0(m_wrreq_bus) && $onehot0(s_rdreq_bus), 1);
      if (gnt_bus != 0) begin
        exp_g = -1;
        for (int k = 0; k < NR; k++)
          if (exp_g < 0 && req_bus[(next_rr + k) % NR]) exp_g = (next_rr + k) % NR;
        check_eq("gnt_rr", gnt_bus, (exp_g >= 0) ? (32'(1) << exp_g) : 0);
        check_eq("gnt_while_busy", inflight, 0);
        check_eq("rsp_hold", rsp_data, last_rsp);
        for (int k = 0; k < NR; k++) if (gnt_bus[k]) cur_owner = k;
        cur_slave = req_slave_bus[4*cur_owner +: 4];
        cur_frame = req_data_bus[FW*cur_owner +: FW];
        cur_bad   = (cur_slave >= NS);
        gnt_cyc   = cyc;
        wr_k      = 0;
        rd_k      = 0;
        inflight  = 1;
        next_rr   = (cur_owner + 1) % NR;
        gnt_log.push_back(cur_owner);
        gnt_seen[cur_owner] = 1'b1;
      end
      if (m_wrreq_bus != 0) begin
        check_eq("wr_sel", m_wrreq_bus, (inflight && !cur_bad) ? (32'(1) << cur_slave) : 0);
        check_eq("wr_byte", m_din, (cur_frame >> (8 * wr_k)) & 8'hFF);
        wr_k++;
        last_wr_cyc = cyc;
      end
      if (s_rdreq_bus != 0) begin
        if (inflight) begin
          check_eq("rd_sel", s_rdreq_bus, 32'(1) << cur_slave);
          rd_k++;
        end else begin
          low_msg = '0;
          for (int s = NS - 1; s >= 0; s--) if (have_msg_bus[s]) begin low_msg = '0; low_msg[s] = 1'b1; end
          check_eq("drain_sel", s_rdreq_bus, low_msg);
          drain_rd++;
        end
      end
      if (done_bus != 0) begin
        check_eq("done_own", done_bus, (inflight && !cur_bad) ? (32'(1) << cur_owner) : 0);
        if (exp_q.size() == 0) check_eq("rsp_expected", 0, 1);
        else begin
          last_rsp = exp_q.pop_front();
          check_eq("rsp_data", rsp_data, last_rsp);
        end
        check_eq("done_wr_cnt", wr_k, NB);
        check_eq("done_rd_cnt", rd_k, NB);
        check_eq("done_latency", cyc - gnt_cyc, 7 + last_delay);
        inflight = 0;
        done_cnt++;
      end
      if (err_bus != 0) begin
        check_eq("err_own", err_bus, inflight ? (32'(1) << cur_owner) : 0);
        if (cur_bad) begin
          check_eq("bad_err_lat", cyc - gnt_cyc, 1);
          check_eq("bad_no_wr", wr_k, 0);
        end else begin
          check_eq("err_allowed", mute, 1);
          check_eq("timeout_lat", cyc - last_wr_cyc, TO + 2);
        end
        inflight = 0;
        err_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_req(input int i, input logic [3:0] slave, input logic [FW-1:0] data);
    req_slave_bus[4*i +: 4]  = slave;
    req_data_bus[FW*i +: FW] = data;
    req_bus[i]               = 1'b1;
  endtask

  task automatic wait_gnt(input int budget, output int own);
    own = -1;
    for (int n = 0; n < budget && own < 0; n++) begin
      tick();
      for (int i = 0; i < NR; i++) if (gnt_seen[i]) begin own = i; gnt_seen[i] = 1'b0; req_bus[i] = 1'b0; end
    end
    check_eq("gnt_arrived", own >= 0, 1);
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    tick();
    while ((inflight || busy) && n < budget) begin tick(); n++; end
    check_eq("quiet_in_budget", n < budget, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_gnt"}, gnt_bus, 0);
    check_eq({tag, "_done"}, done_bus, 0);
    check_eq({tag, "_err"}, err_bus, 0);
    check_eq({tag, "_wr"}, m_wrreq_bus, 0);
    check_eq({tag, "_rd"}, s_rdreq_bus, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_mdin"}, m_din, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check_outputs_zero("reset");
    check_eq("reset_rsp", rsp_data, 0);
    check_eq("reset_state", dbg_state, 0);
    tick();
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int own, d0, e0, n;

  initial begin
    do_reset();

    // Frame 0xA55A to slave 1, slave returns 0x1234 with no wait.
    force_on = 1; force_val = 16'h1234; max_delay = 0;
    d0 = done_cnt;
    set_req(0, 4'd1, 16'hA55A);
    wait_gnt(20, own);
    check_eq("t1_owner", own, 0);
    wait_quiet(50);
    check_eq("t1_done", done_cnt - d0, 1);
    check_eq("t1_rsp", rsp_data, 16'h1234);
    force_on = 0;

    // All four requesters held: grants rotate 0,1,2,3,0.
    do_reset();
    max_delay = 2;
    gnt_log.delete();
    for (int i = 0; i < NR; i++) set_req(i, 4'(i % NS), FW'($urandom));
    n = 0;
    while (gnt_log.size() < 5 && n < 300) begin tick(); n++; end
    req_bus = '0;
    gnt_seen = '0;
    check_eq("rr_in_budget", gnt_log.size() >= 5, 1);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) check_eq("rr_order", gnt_log[k], k % NR);
    wait_quiet(100);

    // Out-of-range slave index.
    e0 = err_cnt;
    set_req(1, 4'd5, FW'($urandom));
    wait_gnt(20, own);
    wait_quiet(20);
    check_eq("bad_slave_err", err_cnt - e0, 1);

    // Slave never answers.
    mute = 1; e0 = err_cnt; d0 = done_cnt;
    set_req(2, 4'd2, FW'($urandom));
    wait_gnt(20, own);
    wait_quiet(100);
    check_eq("timeout_err", err_cnt - e0, 1);
    check_eq("timeout_no_done", done_cnt - d0, 0);
    mute = 0;

    // Stale bytes on slave 0 are drained before the pending request is granted.
    d0 = drain_rd;
    preload_n[0] = 3;
    tick(); tick();
    set_req(3, 4'd0, FW'($urandom));
    wait_gnt(50, own);
    check_eq("drain_reads", drain_rd - d0, 3);
    check_eq("drain_empty", fifo[0].size(), 0);
    wait_quiet(50);

    // Reset in the middle of READ, then a clean transaction.
    max_delay = 0;
    set_req(0, 4'd1, FW'($urandom));
    wait_gnt(20, own);
    n = 0;
    while (rd_k < 1 && n < 50) begin tick(); n++; end
    check_eq("reached_read", rd_k >= 1, 1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst_mid");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_rst");
    check_eq("after_rst_rsp", rsp_data, 0);
    d0 = done_cnt;
    set_req(0, 4'd1, FW'($urandom));
    wait_gnt(50, own);
    check_eq("after_rst_owner", own, 0);
    wait_quiet(50);
    check_eq("after_rst_done", done_cnt - d0, 1);

    // Random traffic.
    max_delay = 6;
    gnt_seen = '0;
    d0 = done_cnt + err_cnt;
    n = 0;
    while (done_cnt + err_cnt < d0 + 40 && n < 5000) begin
      tick(); n++;
      for (int i = 0; i < NR; i++) begin
        if (gnt_seen[i]) begin
          gnt_seen[i] = 1'b0;
          if ($urandom_range(0, 1) == 0) req_bus[i] = 1'b0;
          else set_req(i, 4'($urandom_range(0, 4)), FW'($urandom));
        end else if (!req_bus[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, 4'($urandom_range(0, 4)), FW'($urandom));
        end
      end
    end
    check_eq("random_in_budget", n < 5000, 1);
    req_bus = '0;
    wait_quiet(100);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
